// File: rtl/bitslam_pkg.sv
// Shared constants and types for the bitslam register-bus host.
// Covers register addresses, the FSM state encoding and the queued entry layout.
package bitslam_pkg;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 6;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] REG_V0_DIV  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_V0_TAP  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_V1_DIV  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_V1_TAP  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_MIX_VOL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/bitslam_cmd_fifo.sv
// Synchronous FIFO for queued register writes.
// The head entry is always visible on o_rdata, so a pop consumes the entry shown in the same cycle.
module bitslam_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bitslam_host.sv
// Host for the bitslam synth's write-only register bus.
// Queued {addr,data} writes become registered address/data phases, skipping the address when it is cached.
module bitslam_host
  import bitslam_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [2:0]                    in_addr,
  input  logic [5:0]                    in_data,
  output logic                          in_ready,
  output logic                          bus_sel,
  output logic [5:0]                    bus_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_hold, w_hold_nxt;
  logic                r_sel, w_sel_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [ADDR_W-1:0]   r_last_addr, w_last_addr_nxt;
  logic                r_cache_vld, w_cache_vld_nxt;
  logic [DATA_W-1:0]   r_cur_data, w_cur_data_nxt;
  logic                w_launch;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic [ENTRY_W-1:0]  w_head;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  bitslam_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_wdata ({in_addr, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

  assign w_head_addr = w_head[ENTRY_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign in_ready    = ~w_full;
  assign busy        = ~w_empty | (r_state != ST_IDLE);
  assign bus_sel     = r_sel;
  assign bus_data    = r_data;

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_sel_nxt       = r_sel;
    w_data_nxt      = r_data;
    w_last_addr_nxt = r_last_addr;
    w_cache_vld_nxt = r_cache_vld;
    w_cur_data_nxt  = r_cur_data;
    w_launch        = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt  = 1'b0;
        w_data_nxt = addr_word(r_last_addr);
        w_launch   = ~w_empty;
      end
      ST_ADDR: begin
        if (r_hold != 4'd0) begin
          w_hold_nxt = r_hold - 4'd1;
        end else begin
          w_state_nxt = ST_DATA;
          w_sel_nxt   = 1'b1;
          w_data_nxt  = r_cur_data;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      ST_DATA: begin
        if (r_hold != 4'd0) begin
          w_hold_nxt = r_hold - 4'd1;
        end else if (!w_empty) begin
          w_launch = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = 1'b0;
          w_data_nxt  = addr_word(r_last_addr);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 1'b0;
      end
    endcase
    // Launching a queued write: a repeat of the cached address goes straight to data.
    if (w_launch) begin
      w_pop          = 1'b1;
      w_hold_nxt     = HOLD_LOAD;
      w_cur_data_nxt = w_head_data;
      if (r_cache_vld && (w_head_addr == r_last_addr)) begin
        w_state_nxt = ST_DATA;
        w_sel_nxt   = 1'b1;
        w_data_nxt  = w_head_data;
      end else begin
        w_state_nxt     = ST_ADDR;
        w_sel_nxt       = 1'b0;
        w_data_nxt      = addr_word(w_head_addr);
        w_last_addr_nxt = w_head_addr;
        w_cache_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= 4'd0;
      r_sel       <= 1'b0;
      r_data      <= '0;
      r_last_addr <= '0;
      r_cache_vld <= 1'b0;
      r_cur_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_sel       <= w_sel_nxt;
      r_data      <= w_data_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_cache_vld <= w_cache_vld_nxt;
      r_cur_data  <= w_cur_data_nxt;
    end
  end

endmodule
